// File: rtl/wb_pkg.sv
// Shared Wishbone fabric definitions: state encoding, error data pattern, mainboard slave map.
// Latency: n/a (definitions only). Backpressure: n/a.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } fab_state_e;

  // Read data returned on unmapped or timed-out transfers, sliced to DAT_BITS by users.
  localparam logic [63:0] ERR_PATTERN = '1;

  localparam int SLV_VDP   = 0;
  localparam int SLV_ROM   = 1;
  localparam int SLV_GROM  = 2;
  localparam int SLV_CROM  = 3;
  localparam int SLV_SPROM = 4;
  localparam int SLV_PEB   = 8;

endpackage

// File: rtl/wb_watchdog.sv
// Cycle watchdog: counts enabled cycles from a clear and flags when LIMIT is reached.
// Latency: expired_o is combinational from the count register. Backpressure: none.
module wb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CW'(LIMIT));

  // Saturates at LIMIT so a late clear never sees a wrapped count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_fabric.sv
// Registered single-outstanding Wishbone fabric, one master to NSLAVES slaves; watchdog under WB_FABRIC_TIMEOUT_EN.
// Latency: strobe to ack >= 2 cycles, one transfer per 3 cycles. Backpressure: master holds stb until ack; cyc low aborts.
module wb_fabric
  import wb_pkg::*;
#(
  parameter int NSLAVES  = 8,
  parameter int ADR_BITS = 24,
  parameter int SEL_BITS = 4,
  parameter int DAT_BITS = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [0:ADR_BITS-1]           m_adr_i,
  input  logic [0:DAT_BITS-1]           m_dat_i,
  input  logic                          m_we_i,
  input  logic [0:0]                    m_sel_i,
  input  logic                          m_stb_i,
  input  logic                          m_cyc_i,
  output logic [0:DAT_BITS-1]           m_dat_o,
  output logic                          m_ack_o,
  output logic                          m_err_o,
  output logic [0:ADR_BITS-1]           s_adr_o,
  output logic [0:DAT_BITS-1]           s_dat_o,
  output logic                          s_we_o,
  output logic                          s_sel_o,
  output logic                          s_cyc_o,
  output logic [0:NSLAVES-1]            s_stb_o,
  input  logic [0:NSLAVES*DAT_BITS-1]   s_dat_i,
  input  logic [0:NSLAVES-1]            s_ack_i
);

  if (NSLAVES < 1 || NSLAVES > (1 << SEL_BITS) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_cfg_err
    $error("wb_fabric: parameter out of range");
  end

  fab_state_e          state_q, state_d;
  logic                unmapped_q, unmapped_d;
  logic [0:ADR_BITS-1] s_adr_q, s_adr_d;
  logic [0:DAT_BITS-1] s_dat_q, s_dat_d;
  logic                s_we_q, s_we_d;
  logic                s_sel_q, s_sel_d;
  logic                s_cyc_q, s_cyc_d;
  logic [0:NSLAVES-1]  s_stb_q, s_stb_d;
  logic [0:DAT_BITS-1] m_dat_q, m_dat_d;
  logic                m_ack_q, m_ack_d;
  logic                m_err_q, m_err_d;

  logic [0:SEL_BITS-1] sel_idx;
  logic [0:DAT_BITS-1] rd_dat;
  logic                ack_hit;
  logic                wd_expired;

  assign sel_idx = m_adr_i[0 +: SEL_BITS];

  // The strobe register is one-hot on the selected slave, so it doubles as the ack/data select.
  assign ack_hit = |(s_ack_i & s_stb_q);

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (s_stb_q[k]) begin
        rd_dat = s_dat_i[k*DAT_BITS +: DAT_BITS];
      end
    end
  end

`ifdef WB_FABRIC_TIMEOUT_EN
  logic wd_en;
  logic wd_clr;

  assign wd_en  = (state_q == ST_ACTIVE) && !unmapped_q;
  assign wd_clr = (state_q != ST_ACTIVE);

  wb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    unmapped_d = unmapped_q;
    s_adr_d    = s_adr_q;
    s_dat_d    = s_dat_q;
    s_we_d     = s_we_q;
    s_sel_d    = s_sel_q;
    s_cyc_d    = s_cyc_q;
    s_stb_d    = s_stb_q;
    m_dat_d    = m_dat_q;
    m_err_d    = m_err_q;
    m_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          s_adr_d = m_adr_i;
          s_dat_d = m_dat_i;
          s_we_d  = m_we_i;
          s_sel_d = m_sel_i[0];
          // Unmapped accesses also pass through ACTIVE (with no strobe) so their ack lands at cycle 2 like a fast slave.
          state_d = ST_ACTIVE;
          if (32'(sel_idx) < NSLAVES) begin
            unmapped_d = 1'b0;
            s_cyc_d    = 1'b1;
            for (int k = 0; k < NSLAVES; k++) begin
              s_stb_d[k] = (32'(sel_idx) == k);
            end
          end else begin
            unmapped_d = 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        if (!m_cyc_i) begin
          s_stb_d = '0;
          s_cyc_d = 1'b0;
          state_d = ST_IDLE;
        end else if (unmapped_q || (!ack_hit && wd_expired)) begin
          s_stb_d = '0;
          s_cyc_d = 1'b0;
          m_dat_d = ERR_PATTERN[DAT_BITS-1:0];
          m_err_d = 1'b1;
          m_ack_d = 1'b1;
          state_d = ST_RESP;
        end else if (ack_hit) begin
          if (!s_we_q) begin
            m_dat_d = rd_dat;
          end
          s_stb_d = '0;
          s_cyc_d = 1'b0;
          m_err_d = 1'b0;
          m_ack_d = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        s_stb_d = '0;
        s_cyc_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      unmapped_q <= 1'b0;
      s_adr_q    <= '0;
      s_dat_q    <= '0;
      s_we_q     <= 1'b0;
      s_sel_q    <= 1'b0;
      s_cyc_q    <= 1'b0;
      s_stb_q    <= '0;
      m_dat_q    <= '0;
      m_ack_q    <= 1'b0;
      m_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      unmapped_q <= unmapped_d;
      s_adr_q    <= s_adr_d;
      s_dat_q    <= s_dat_d;
      s_we_q     <= s_we_d;
      s_sel_q    <= s_sel_d;
      s_cyc_q    <= s_cyc_d;
      s_stb_q    <= s_stb_d;
      m_dat_q    <= m_dat_d;
      m_ack_q    <= m_ack_d;
      m_err_q    <= m_err_d;
    end
  end

  assign m_dat_o = m_dat_q;
  assign m_ack_o = m_ack_q;
  assign m_err_o = m_err_q;
  assign s_adr_o = s_adr_q;
  assign s_dat_o = s_dat_q;
  assign s_we_o  = s_we_q;
  assign s_sel_o = s_sel_q;
  assign s_cyc_o = s_cyc_q;
  assign s_stb_o = s_stb_q;

endmodule

// File: tb/tb_wb_fabric.sv
// Directed bench for wb_fabric with a response scoreboard; expectations follow WB_FABRIC_TIMEOUT_EN.
module tb_wb_fabric;
  import wb_pkg::*;

  localparam int NS = 8;
  localparam int AB = 24;
  localparam int SB = 4;
  localparam int DB = 8;
  localparam int TO = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [0:AB-1]      m_adr_i;
  logic [0:DB-1]      m_dat_i;
  logic               m_we_i;
  logic [0:0]         m_sel_i;
  logic               m_stb_i;
  logic               m_cyc_i;
  logic [0:DB-1]      m_dat_o;
  logic               m_ack_o;
  logic               m_err_o;
  logic [0:AB-1]      s_adr_o;
  logic [0:DB-1]      s_dat_o;
  logic               s_we_o;
  logic               s_sel_o;
  logic               s_cyc_o;
  logic [0:NS-1]      s_stb_o;
  logic [0:NS*DB-1]   s_dat_i;
  logic [0:NS-1]      s_ack_i;

  wb_fabric #(
    .NSLAVES (NS),
    .ADR_BITS(AB),
    .SEL_BITS(SB),
    .DAT_BITS(DB),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_we_i  (m_we_i),
    .m_sel_i (m_sel_i),
    .m_stb_i (m_stb_i),
    .m_cyc_i (m_cyc_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:DB-1] dat;
    logic          err;
    logic          chk_dat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:NS-1] oh(input int k);
    logic [0:NS-1] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  // Drives one master transfer; cycle 1 is the first cycle after the request edge.
  task automatic xfer(input logic [0:AB-1] adr, input logic we, input logic [0:DB-1] wdat,
                      input int exp_slave, input int ack_slave, input int ack_lat,
                      input int noise_slave, input int budget,
                      output int stb_c, output int ack_c);
    logic [0:NS-1] exp_oh;
    logic          bad_stb;
    exp_t          e;
    exp_oh  = oh(exp_slave);
    bad_stb = 1'b0;
    stb_c   = -1;
    ack_c   = -1;
    m_adr_i = adr;
    m_we_i  = we;
    m_dat_i = wdat;
    m_sel_i = 1'b1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (m_ack_o) begin
        ack_c = c;
        chk("ack_strobes_dropped", {s_cyc_o, s_stb_o}, 0);
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_err", m_err_o, e.err);
          if (e.chk_dat) chk("rsp_dat", m_dat_o, e.dat);
        end
        break;
      end
      if (s_stb_o != '0 && stb_c < 0) begin
        stb_c = c;
        chk("s_adr", s_adr_o, adr);
        chk("s_dat", s_dat_o, wdat);
        chk("s_we", s_we_o, we);
        chk("s_sel", s_sel_o, 1);
        chk("s_cyc", s_cyc_o, 1);
      end
      if (s_stb_o != '0 && s_stb_o != exp_oh) bad_stb = 1'b1;
      s_ack_i = '0;
      if (ack_slave >= 0 && stb_c >= 0 && c >= stb_c + ack_lat && s_stb_o[ack_slave])
        s_ack_i[ack_slave] = 1'b1;
      if (noise_slave >= 0) s_ack_i[noise_slave] = 1'b1;
    end
    s_ack_i = '0;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    chk("stb_onehot", bad_stb, 0);
    if (ack_c > 0) begin
      tick();
      chk("ack_one_pulse", m_ack_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int stb_c;
    int ack_c;

    reset_n = 1'b0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_we_i  = 1'b0;
    m_sel_i = 1'b0;
    m_stb_i = 1'b0;
    m_cyc_i = 1'b0;
    s_ack_i = '0;
    for (int k = 0; k < NS; k++) s_dat_i[k*DB +: DB] = 8'(8'h10 + k);
    s_dat_i[SLV_GROM*DB +: DB] = 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_m_err", m_err_o, 0);
    chk("rst_m_dat", m_dat_o, 0);
    chk("rst_s_stb_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_s_we_sel", {s_we_o, s_sel_o}, 0);
    reset_n = 1'b1;
    tick();

    // Read GROM, slave acks one cycle after its strobe.
    sb.push_back('{8'h5A, 1'b0, 1'b1});
    xfer(24'h200010, 1'b0, 8'h00, SLV_GROM, SLV_GROM, 1, -1, 20, stb_c, ack_c);
    chk("rd_stb_cycle", stb_c, 1);
    chk("rd_ack_cycle", ack_c, 3);

    // Write to VDP with a combinational ack.
    sb.push_back('{8'h00, 1'b0, 1'b0});
    xfer(24'h000123, 1'b1, 8'h3C, SLV_VDP, SLV_VDP, 0, -1, 20, stb_c, ack_c);
    chk("wr_stb_cycle", stb_c, 1);
    chk("wr_ack_cycle", ack_c, 2);

    // Unmapped top nibble.
    sb.push_back('{8'hFF, 1'b1, 1'b1});
    xfer(24'hF00000, 1'b0, 8'h00, -1, -1, 0, -1, 20, stb_c, ack_c);
    chk("unm_no_stb", stb_c, -1);
    chk("unm_ack_cycle", ack_c, 2);

    // Slave 5 acks constantly while ROM is active; only ROM's ack may complete.
    sb.push_back('{8'h11, 1'b0, 1'b1});
    xfer(24'h1ABCDE, 1'b0, 8'h00, SLV_ROM, SLV_ROM, 3, 5, 20, stb_c, ack_c);
    chk("ign_ack_cycle", ack_c, 5);

`ifdef WB_FABRIC_TIMEOUT_EN
    sb.push_back('{8'hFF, 1'b1, 1'b1});
    xfer(24'h600000, 1'b0, 8'h00, 6, -1, 0, -1, 20, stb_c, ack_c);
    chk("to_stb_cycle", stb_c, 1);
    chk("to_ack_cycle", ack_c, TO + 2);
`else
    xfer(24'h600000, 1'b0, 8'h00, 6, -1, 0, -1, 100, stb_c, ack_c);
    chk("hang_no_ack", ack_c, -1);
    chk("hang_stb_held", s_stb_o, oh(6));
    chk("hang_cyc_held", s_cyc_o, 1);
    tick();
    chk("hang_abort_drop", {s_cyc_o, s_stb_o}, 0);
    chk("hang_abort_no_ack", m_ack_o, 0);
`endif

    // Abort and ack in the same cycle: abort wins.
    m_adr_i = 24'h400000;
    m_we_i  = 1'b0;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    tick();
    chk("ab_stb_up", s_stb_o, oh(SLV_SPROM));
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    s_ack_i[SLV_SPROM] = 1'b1;
    tick();
    s_ack_i = '0;
    chk("ab_drop", {s_cyc_o, s_stb_o}, 0);
    chk("ab_no_ack", m_ack_o, 0);
    tick();
    chk("ab_no_ack_late", m_ack_o, 0);

    sb.push_back('{8'h14, 1'b0, 1'b1});
    xfer(24'h400001, 1'b0, 8'h00, SLV_SPROM, SLV_SPROM, 0, -1, 20, stb_c, ack_c);
    chk("post_ab_stb_cycle", stb_c, 1);
    chk("post_ab_ack_cycle", ack_c, 2);

    // Asynchronous reset in the middle of a CROM write.
    m_adr_i = 24'h300055;
    m_dat_i = 8'hA5;
    m_we_i  = 1'b1;
    m_sel_i = 1'b1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    tick();
    tick();
    chk("mr_stb_up", s_stb_o, oh(SLV_CROM));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_stb_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("mr_we_sel", {s_we_o, s_sel_o}, 0);
    chk("mr_s_adr", s_adr_o, 0);
    chk("mr_s_dat", s_dat_o, 0);
    chk("mr_m_dat", m_dat_o, 0);
    chk("mr_m_ack_err", {m_ack_o, m_err_o}, 0);
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();

    sb.push_back('{8'h5A, 1'b0, 1'b1});
    xfer(24'h2FFFFF, 1'b0, 8'h00, SLV_GROM, SLV_GROM, 0, -1, 20, stb_c, ack_c);
    chk("post_rst_ack_cycle", ack_c, 2);

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
